// File: rtl/pic_pkg.sv
// Shared widths and types for the sparse-matrix multiply cell.
// Operands are 16-bit unsigned; products keep the full 32 bits.
package pic_pkg;
  localparam int PIC_DATA_W = 16;
  localparam int PIC_PROD_W = 32;

  typedef logic [PIC_DATA_W-1:0] operand_t;
  typedef logic [PIC_PROD_W-1:0] product_t;
endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with a registered pop output. Pop data lands on rd_dat one clock after pop.
// A push while full is accepted only if a pop frees the slot on the same edge; a pop while empty is ignored.
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wr_dat,
  input  logic         pop,
  output logic [W-1:0] rd_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // A pop on the same edge frees the slot the push lands in.
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rd_dat <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        rd_dat <= mem[rd_ptr];
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is left unreset; stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_dat;
  end
endmodule

// File: rtl/pic_mult_fifo.sv
// Multiplies A0*B0 to a full-width product and queues it; popped products appear on fifo_Out one clock after read.
// Writes while full are dropped unless a read frees a slot on the same edge; reads while empty are ignored.
module pic_mult_fifo
  import pic_pkg::*;
#(
  parameter int DATA_W = PIC_DATA_W,
  parameter int DEPTH  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   A0,
  input  logic [DATA_W-1:0]   B0,
  input  logic                write,
  input  logic                read,
  output logic [2*DATA_W-1:0] fifo_Out,
  output logic                full,
  output logic                empty
);
  localparam int PROD_W = 2 * DATA_W;

  logic [PROD_W-1:0] product;

  assign product = PROD_W'(A0) * PROD_W'(B0);

  sync_fifo #(
    .W     (PROD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (write),
    .wr_dat (product),
    .pop    (read),
    .rd_dat (fifo_Out),
    .full   (full),
    .empty  (empty)
  );
endmodule

// File: tb/tb_pic_mult_fifo.sv
// Bench for pic_mult_fifo: fixed vector table, hand-written corner sequences and a randomized run
// compared against a queue-based model of the FIFO.
module tb_pic_mult_fifo;
  import pic_pkg::*;

  localparam int DEPTH = 8;

  logic     clk;
  logic     rst_n;
  operand_t A0;
  operand_t B0;
  logic     write;
  logic     read;
  product_t fifo_Out;
  logic     full;
  logic     empty;

  int checks = 0;
  int errors = 0;

  product_t q[$];
  product_t m_out;

  typedef struct {
    bit       wr;
    bit       rd;
    operand_t a;
    operand_t b;
    product_t exp_out;
    bit       exp_empty;
    bit       exp_full;
  } vec_t;

  vec_t tbl[14];

  pic_mult_fifo #(.DATA_W(16), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A0       (A0),
    .B0       (B0),
    .write    (write),
    .read     (read),
    .fifo_Out (fifo_Out),
    .full     (full),
    .empty    (empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, then advance the model and compare just after the edge.
  task automatic cycle(input bit wr, input bit rd, input operand_t a, input operand_t b);
    bit do_pop;
    bit do_push;
    @(negedge clk);
    write = wr;
    read  = rd;
    A0    = a;
    B0    = b;
    @(posedge clk);
    #1;
    do_pop  = rd && (q.size() != 0);
    do_push = wr && ((q.size() < DEPTH) || rd);
    if (do_pop) m_out = q.pop_front();
    if (do_push) q.push_back(product_t'(a) * product_t'(b));
    chk("fifo_Out", fifo_Out, m_out);
    chk("full", {31'b0, full}, {31'b0, q.size() == DEPTH});
    chk("empty", {31'b0, empty}, {31'b0, q.size() == 0});
  endtask

  // Assert reset mid-cycle and check the outputs clear before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    write = 1'b0;
    read  = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    m_out = '0;
    chk("rst fifo_Out", fifo_Out, 32'h0);
    chk("rst empty", {31'b0, empty}, 32'h1);
    chk("rst full", {31'b0, full}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 16'hE352, 16'hB95B, 32'h0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 16'hE352, 16'hE352, 32'h0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 16'h0003, 16'h0003, 32'h0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 16'hE352, 16'hB95B, 32'h0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 16'hE352, 16'hB95B, 32'h0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 16'hFFFF, 16'hFFFE, 32'h0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 16'h1234, 16'h5678, 32'h0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 16'h0, 16'h0, 32'hA4971026, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 16'h0, 16'h0, 32'hC9DA8644, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 16'h0, 16'h0, 32'h00000009, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 16'h0, 16'h0, 32'hA4971026, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 16'h0, 16'h0, 32'hA4971026, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 16'h0, 16'h0, 32'hFFFD0002, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 16'h0, 16'h0, 32'h06260060, 1'b1, 1'b0};

    rst_n = 1'b0;
    write = 1'b0;
    read  = 1'b0;
    A0    = '0;
    B0    = '0;
    m_out = '0;
    #1;
    chk("init fifo_Out", fifo_Out, 32'h0);
    chk("init empty", {31'b0, empty}, 32'h1);
    chk("init full", {31'b0, full}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    do_reset();
    cycle(1'b0, 1'b0, 16'h0, 16'h0);

    // Seven writes then seven reads from the vector table.
    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].wr, tbl[i].rd, tbl[i].a, tbl[i].b);
      chk($sformatf("tbl[%0d] fifo_Out", i), fifo_Out, tbl[i].exp_out);
      chk($sformatf("tbl[%0d] empty", i), {31'b0, empty}, {31'b0, tbl[i].exp_empty});
      chk($sformatf("tbl[%0d] full", i), {31'b0, full}, {31'b0, tbl[i].exp_full});
    end

    // Overflow: the ninth write is dropped.
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, 1'b0, 16'h0002, 16'h0003);
      if (i == 7) chk("ovf full after 8", {31'b0, full}, 32'h1);
    end
    chk("ovf full after 9", {31'b0, full}, 32'h1);
    for (int i = 0; i < 9; i++) begin
      cycle(1'b0, 1'b1, 16'h0, 16'h0);
      chk($sformatf("ovf pop %0d", i), fifo_Out, 32'h00000006);
    end
    chk("ovf empty", {31'b0, empty}, 32'h1);

    // Underflow and simultaneous access while empty.
    cycle(1'b0, 1'b1, 16'h0, 16'h0);
    chk("udf hold", fifo_Out, 32'h00000006);
    cycle(1'b1, 1'b1, 16'h0004, 16'h0005);
    chk("wr+rd empty out", fifo_Out, 32'h00000006);
    chk("wr+rd empty flag", {31'b0, empty}, 32'h0);
    cycle(1'b0, 1'b1, 16'h0, 16'h0);
    chk("wr+rd pop", fifo_Out, 32'h00000014);

    // Simultaneous access while full: oldest leaves, new product joins the tail.
    for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 16'(i), 16'h0001);
    cycle(1'b1, 1'b1, 16'h0007, 16'h0064);
    chk("full rw out", fifo_Out, 32'h1);
    chk("full rw full", {31'b0, full}, 32'h1);
    for (int i = 2; i <= 8; i++) begin
      cycle(1'b0, 1'b1, 16'h0, 16'h0);
      chk($sformatf("full rw pop %0d", i), fifo_Out, 32'(i));
    end
    cycle(1'b0, 1'b1, 16'h0, 16'h0);
    chk("full rw tail", fifo_Out, 32'd700);
    chk("full rw empty", {31'b0, empty}, 32'h1);

    // Reset mid-stream flushes the queued products.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'h0010, 16'(i + 1));
    do_reset();
    cycle(1'b0, 1'b1, 16'h0, 16'h0);
    chk("post-rst read out", fifo_Out, 32'h0);
    chk("post-rst read empty", {31'b0, empty}, 32'h1);
    cycle(1'b1, 1'b0, 16'h0009, 16'h0009);
    cycle(1'b0, 1'b1, 16'h0, 16'h0);
    chk("post-rst pop", fifo_Out, 32'd81);

    // Randomized traffic: a fill-biased phase then a drain-biased phase.
    for (int i = 0; i < 1600; i++) begin
      int  wp;
      int  rp;
      bit  wr;
      bit  rd;
      operand_t a;
      operand_t b;
      wp = (i < 800) ? 70 : 35;
      rp = (i < 800) ? 35 : 70;
      wr = ($urandom_range(0, 99) < wp);
      rd = ($urandom_range(0, 99) < rp);
      a  = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
      b  = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
      cycle(wr, rd, a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
